cv32e40p_fault_manager: RTL and testbench
=========================================

// Module: cv32e40p_fault_manager
// PURPOSE
//  Consumes per-cycle mismatch pulses ("detected") from the TMR voters of the
//  fault-tolerant decode stages. Records sticky per-source flags and a
//  saturating total count, and raises an interrupt request with an ack handshake.
//  Raises a sticky escalation flag once the count reaches a threshold.
//  Sits beside the ID stage; irq_o feeds the controller/CLIC, escalate_o feeds SoC recovery.
// PARAMETERS
//  NUM_SRC     3  number of voter fault sources (1..16)
//  CNT_W       8  width of total fault counter
//  ESC_THRESH  4  total count at/above which escalate_o asserts (1..2**CNT_W-1)
// PORTS
//  clk          in   1        core clock
//  rst_n        in   1        asynchronous active-low reset
//  fault_i      in   NUM_SRC  voter detected pulses, sampled every cycle
//  clear_i      in   1        software clear of flags, count, escalation
//  irq_ack_i    in   1        interrupt acknowledge (1-cycle pulse or level)
//  irq_o        out  1        fault interrupt request
//  escalate_o   out  1        sticky threshold-reached flag
//  sticky_o     out  NUM_SRC  sticky per-source fault flags
//  total_cnt_o  out  CNT_W    saturating number of source-faults seen
//  last_src_o   out  NUM_SRC  fault_i value of the most recent faulty cycle (FAULT_LOG_EN only)
//  last_ts_o    out  32       free-running cycle stamp of that event (FAULT_LOG_EN only)
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, pending=0, cycle stamp=0.
//  Counting: each cycle total_cnt += popcount(fault_i), saturates at 2**CNT_W-1, never wraps.
//  sticky_o |= fault_i each cycle. Registered outputs, 1-cycle latency from fault_i.
//  escalate_o <= 1 in the cycle after total_cnt first becomes >= ESC_THRESH; held until clear_i.
//  FSM (cv32e40p_pkg::fault_mgr_state_e):
//   IDLE:   |fault_i -> REPORT (irq_o=1 next cycle).
//   REPORT: irq_o=1. irq_ack_i & ~|fault_i & ~pending -> IDLE.
//           A fault arriving while in REPORT sets pending.
//           irq_ack_i with pending, or with a fault in the same cycle: clear pending,
//           drop irq_o for one cycle -> REARM.
//   REARM:  irq_o=0 for exactly one cycle -> REPORT. This gives a fresh rising edge.
//           A fault here sets pending.
//  clear_i: zeroes sticky_o, total_cnt_o, escalate_o, pending, and forces IDLE.
//   The same-cycle fault_i is then applied on top. Example: clear with fault_i=3'b010
//   gives sticky=010, cnt=1, and the FSM goes to REPORT.
//  clear_i does not clear last_src_o or last_ts_o.
//  rst_n deasserted mid-operation: immediate return to reset values, no irq glitch beyond reset.
//  ESC_THRESH is compared against the saturated value, so it is reachable for all legal settings.
// CONFIGURATION
//  CV32E40P_FAULT_LOG_EN defined:
//   - 32-bit free-running cycle stamp (wraps modulo 2**32).
//   - On any cycle with |fault_i: last_src_o<=fault_i and last_ts_o<=stamp.
//  Undefined: last_src_o and last_ts_o tied to 0, no stamp register.
//   Other behaviour identical.
// STRUCTURE
//  cv32e40p_pkg: fault_mgr_state_e {FM_IDLE, FM_REPORT, FM_REARM}, FM_STAMP_W=32.
//  Sub-module cv32e40p_fault_sat_counter (parameter W; inputs inc amount, clear; output saturating value).
//  The FSM, flags and log stay in the top module.
// TESTING
//  1 Single fault: fault_i=001 for 1 cycle.
//    -> next cycle sticky=001, cnt=1, irq_o=1.
//    -> ack -> irq_o=0 and IDLE.
//  2 Simultaneous: fault_i=111 once with ESC_THRESH=4.
//    -> cnt=3, escalate_o=0.
//    -> a further fault_i=010 gives cnt=4 and escalate_o=1 the following cycle.
//  3 Fault during REPORT, then ack.
//    -> irq_o low exactly 1 cycle (REARM), then high again.
//    -> second ack with no faults -> IDLE.
//  4 Saturation: CNT_W=4, 20 cycles of fault_i=001.
//    -> cnt holds 15, no wrap.
//  5 clear_i with fault_i=100 in the same cycle.
//    -> sticky=100, cnt=1, escalate_o=0, irq_o=1.
//  6 FAULT_LOG_EN: fault_i=010 at stamp 37.
//    -> last_src_o=010, last_ts_o=37.
//    -> after a later clear_i both values persist.
//    -> rst_n low mid-REPORT zeroes all outputs.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared types for the fault-tolerant decode fault manager.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    FM_IDLE   = 2'd0,
    FM_REPORT = 2'd1,
    FM_REARM  = 2'd2
  } fault_mgr_state_e;

  localparam int unsigned FM_STAMP_W = 32;

endpackage

// File: rtl/cv32e40p_fault_sat_counter.sv
// Saturating up-counter: adds a variable increment per cycle, clear restarts from zero
// with the same-cycle increment still applied.
module cv32e40p_fault_sat_counter #(
  parameter int unsigned W     = 8,
  parameter int unsigned INC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INC_W-1:0] i_inc,
  input  logic             i_clr,
  output logic [W-1:0]     o_value
);

  localparam int unsigned SUM_W = ((W > INC_W) ? W : INC_W) + 1;
  localparam logic [SUM_W-1:0] L_MAX = SUM_W'({W{1'b1}});

  logic [W-1:0]     r_val;
  logic [SUM_W-1:0] w_base;
  logic [SUM_W-1:0] w_sum;
  logic [W-1:0]     w_next;

  assign w_base = i_clr ? '0 : SUM_W'(r_val);
  assign w_sum  = w_base + SUM_W'(i_inc);
  assign w_next = (w_sum > L_MAX) ? {W{1'b1}} : w_sum[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_val <= '0;
    else        r_val <= w_next;
  end

  assign o_value = r_val;

endmodule

// File: rtl/cv32e40p_fault_manager.sv
// TMR voter fault manager: sticky flags, saturating count, escalation and irq/ack FSM.
// Optional event log (last source + cycle stamp) enabled by CV32E40P_FAULT_LOG_EN.
module cv32e40p_fault_manager
  import cv32e40p_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned ESC_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    fault_i,
  input  logic                  clear_i,
  input  logic                  irq_ack_i,
  output logic                  irq_o,
  output logic                  escalate_o,
  output logic [NUM_SRC-1:0]    sticky_o,
  output logic [CNT_W-1:0]      total_cnt_o,
  output logic [NUM_SRC-1:0]    last_src_o,
  output logic [FM_STAMP_W-1:0] last_ts_o
);

  localparam int unsigned INC_W = $clog2(NUM_SRC + 1);
  localparam logic [CNT_W-1:0] L_THRESH = CNT_W'(ESC_THRESH);

  fault_mgr_state_e   r_state;
  logic               r_irq;
  logic               r_pend;
  logic               r_esc;
  logic [NUM_SRC-1:0] r_sticky;
  logic [CNT_W-1:0]   w_cnt;
  logic [INC_W-1:0]   w_pop;
  logic               w_any;

  assign w_any = |fault_i;
  assign w_pop = INC_W'($countones(fault_i));

  cv32e40p_fault_sat_counter #(
    .W     (CNT_W),
    .INC_W (INC_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_pop),
    .i_clr   (clear_i),
    .o_value (w_cnt)
  );

  // Escalation looks at the registered (already saturated) count, so it lags the count by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
      r_esc    <= 1'b0;
    end else begin
      r_sticky <= (clear_i ? '0 : r_sticky) | fault_i;
      r_esc    <= clear_i ? 1'b0 : (r_esc | (w_cnt >= L_THRESH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FM_IDLE;
      r_irq   <= 1'b0;
      r_pend  <= 1'b0;
    end else if (clear_i) begin
      r_pend  <= 1'b0;
      r_state <= w_any ? FM_REPORT : FM_IDLE;
      r_irq   <= w_any;
    end else begin
      case (r_state)
        FM_IDLE: begin
          if (w_any) begin
            r_state <= FM_REPORT;
            r_irq   <= 1'b1;
          end
        end
        FM_REPORT: begin
          if (irq_ack_i) begin
            r_pend <= 1'b0;
            r_irq  <= 1'b0;
            // Unserviced faults force a one-cycle gap so the controller sees a new edge.
            r_state <= (r_pend | w_any) ? FM_REARM : FM_IDLE;
          end else if (w_any) begin
            r_pend <= 1'b1;
          end
        end
        FM_REARM: begin
          r_state <= FM_REPORT;
          r_irq   <= 1'b1;
          if (w_any) r_pend <= 1'b1;
        end
        default: begin
          r_state <= FM_IDLE;
          r_irq   <= 1'b0;
          r_pend  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CV32E40P_FAULT_LOG_EN
  logic [FM_STAMP_W-1:0] r_stamp;
  logic [NUM_SRC-1:0]    r_last_src;
  logic [FM_STAMP_W-1:0] r_last_ts;

  // Log is deliberately untouched by clear_i; only reset wipes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stamp    <= '0;
      r_last_src <= '0;
      r_last_ts  <= '0;
    end else begin
      r_stamp <= r_stamp + 1'b1;
      if (w_any) begin
        r_last_src <= fault_i;
        r_last_ts  <= r_stamp;
      end
    end
  end

  assign last_src_o = r_last_src;
  assign last_ts_o  = r_last_ts;
`else
  assign last_src_o = '0;
  assign last_ts_o  = '0;
`endif

  assign irq_o       = r_irq;
  assign escalate_o  = r_esc;
  assign sticky_o    = r_sticky;
  assign total_cnt_o = w_cnt;

endmodule

// File: tb/tb_cv32e40p_fault_manager.sv
// Self-checking bench for cv32e40p_fault_manager: directed scenarios plus random traffic
// against a behavioural model (NUM_SRC=3, CNT_W=4, ESC_THRESH=4).
module tb_cv32e40p_fault_manager;

  localparam int NSRC   = 3;
  localparam int CW     = 4;
  localparam int THRESH = 4;
  localparam int CMAX   = (1 << CW) - 1;

  logic            clk;
  logic            rst_n;
  logic [NSRC-1:0] fault_i;
  logic            clear_i;
  logic            irq_ack_i;
  logic            irq_o;
  logic            escalate_o;
  logic [NSRC-1:0] sticky_o;
  logic [CW-1:0]   total_cnt_o;
  logic [NSRC-1:0] last_src_o;
  logic [31:0]     last_ts_o;

  cv32e40p_fault_manager #(
    .NUM_SRC    (NSRC),
    .CNT_W      (CW),
    .ESC_THRESH (THRESH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fault_i     (fault_i),
    .clear_i     (clear_i),
    .irq_ack_i   (irq_ack_i),
    .irq_o       (irq_o),
    .escalate_o  (escalate_o),
    .sticky_o    (sticky_o),
    .total_cnt_o (total_cnt_o),
    .last_src_o  (last_src_o),
    .last_ts_o   (last_ts_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: interrupt line tracked as "raised", "gap" (forced low one cycle) or "quiet".
  int              m_cnt;
  logic [NSRC-1:0] m_sticky;
  bit              m_esc;
  bit              m_raised;
  bit              m_gap;
  bit              m_owed;
  int unsigned     m_stamp;
  logic [NSRC-1:0] m_last_src;
  int unsigned     m_last_ts;

  task automatic model_reset();
    m_cnt = 0; m_sticky = '0; m_esc = 0; m_raised = 0; m_gap = 0; m_owed = 0;
    m_stamp = 0; m_last_src = '0; m_last_ts = 0;
  endtask

  task automatic model_edge(input logic [NSRC-1:0] f, input bit clr, input bit ack);
    int  pop;
    bit  any;
    pop = $countones(f);
    any = (f != 0);
    if (any) begin
      m_last_src = f;
      m_last_ts  = m_stamp;
    end
    m_stamp = m_stamp + 1;
    if (clr) begin
      m_cnt    = (pop > CMAX) ? CMAX : pop;
      m_sticky = f;
      m_esc    = 0;
      m_owed   = 0;
      m_gap    = 0;
      m_raised = any;
    end else begin
      m_esc    = m_esc || (m_cnt >= THRESH);
      m_cnt    = (m_cnt + pop > CMAX) ? CMAX : m_cnt + pop;
      m_sticky = m_sticky | f;
      if (m_gap) begin
        m_gap    = 0;
        m_raised = 1;
        if (any) m_owed = 1;
      end else if (m_raised) begin
        if (ack) begin
          m_raised = 0;
          m_gap    = m_owed || any;
          m_owed   = 0;
        end else if (any) begin
          m_owed = 1;
        end
      end else if (any) begin
        m_raised = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".irq"},    32'(irq_o),       32'(m_raised));
    check_eq({tag, ".esc"},    32'(escalate_o),  32'(m_esc));
    check_eq({tag, ".sticky"}, 32'(sticky_o),    32'(m_sticky));
    check_eq({tag, ".cnt"},    32'(total_cnt_o), 32'(m_cnt));
`ifdef CV32E40P_FAULT_LOG_EN
    check_eq({tag, ".lsrc"},   32'(last_src_o),  32'(m_last_src));
    check_eq({tag, ".lts"},    last_ts_o,        m_last_ts);
`else
    check_eq({tag, ".lsrc"},   32'(last_src_o),  32'd0);
    check_eq({tag, ".lts"},    last_ts_o,        32'd0);
`endif
  endtask

  task automatic step(input logic [NSRC-1:0] f, input bit clr, input bit ack, input string tag);
    fault_i   = f;
    clear_i   = clr;
    irq_ack_i = ack;
    @(posedge clk);
    model_edge(f, clr, ack);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fault_i = '0; clear_i = 1'b0; irq_ack_i = 1'b0;
    #2;
    check_eq("rst.irq",    32'(irq_o),       32'd0);
    check_eq("rst.esc",    32'(escalate_o),  32'd0);
    check_eq("rst.sticky", 32'(sticky_o),    32'd0);
    check_eq("rst.cnt",    32'(total_cnt_o), 32'd0);
    check_eq("rst.lsrc",   32'(last_src_o),  32'd0);
    check_eq("rst.lts",    last_ts_o,        32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    fault_i = '0; clear_i = 1'b0; irq_ack_i = 1'b0;
    do_reset();

    // Single fault, then ack
    step(3'b001, 0, 0, "t1.f");
    check_eq("t1.irq_hi", 32'(irq_o), 32'd1);
    check_eq("t1.cnt1", 32'(total_cnt_o), 32'd1);
    step(3'b000, 0, 1, "t1.ack");
    check_eq("t1.irq_lo", 32'(irq_o), 32'd0);
    step(3'b000, 0, 0, "t1.idle");
    step(3'b000, 1, 0, "t1.clr");

    // Simultaneous faults and escalation threshold
    step(3'b111, 0, 0, "t2.a");
    check_eq("t2.cnt3", 32'(total_cnt_o), 32'd3);
    check_eq("t2.esc0", 32'(escalate_o), 32'd0);
    step(3'b010, 0, 0, "t2.b");
    check_eq("t2.cnt4", 32'(total_cnt_o), 32'd4);
    step(3'b000, 0, 0, "t2.c");
    check_eq("t2.esc1", 32'(escalate_o), 32'd1);
    step(3'b000, 1, 0, "t2.clr");

    // Fault during REPORT, ack -> one-cycle gap -> re-raise -> ack -> idle
    step(3'b001, 0, 0, "t3.f");
    step(3'b100, 0, 0, "t3.f2");
    step(3'b000, 0, 1, "t3.ack1");
    check_eq("t3.gap", 32'(irq_o), 32'd0);
    step(3'b000, 0, 0, "t3.rearm");
    check_eq("t3.rehi", 32'(irq_o), 32'd1);
    step(3'b000, 0, 1, "t3.ack2");
    check_eq("t3.lo", 32'(irq_o), 32'd0);
    step(3'b000, 0, 0, "t3.idle");
    check_eq("t3.stay", 32'(irq_o), 32'd0);
    step(3'b000, 1, 0, "t3.clr");

    // Saturation
    for (int i = 0; i < 20; i++) step(3'b001, 0, 0, "t4.sat");
    check_eq("t4.cnt15", 32'(total_cnt_o), 32'd15);

    // Clear with same-cycle fault
    step(3'b100, 1, 0, "t5.clr");
    check_eq("t5.sticky", 32'(sticky_o), 32'b100);
    check_eq("t5.cnt", 32'(total_cnt_o), 32'd1);
    check_eq("t5.esc", 32'(escalate_o), 32'd0);
    check_eq("t5.irq", 32'(irq_o), 32'd1);

    // Log stamp, persistence across clear, async reset mid-REPORT
    step(3'b000, 0, 0, "t6.pre");
    do_reset();
    while (m_stamp != 37) step(3'b000, 0, 0, "t6.wait");
    step(3'b010, 0, 0, "t6.log");
`ifdef CV32E40P_FAULT_LOG_EN
    check_eq("t6.lsrc", 32'(last_src_o), 32'b010);
    check_eq("t6.lts", last_ts_o, 32'd37);
`endif
    step(3'b000, 1, 0, "t6.clr");
`ifdef CV32E40P_FAULT_LOG_EN
    check_eq("t6.lsrc_keep", 32'(last_src_o), 32'b010);
    check_eq("t6.lts_keep", last_ts_o, 32'd37);
`endif
    step(3'b001, 0, 0, "t6.rep");
    check_eq("t6.irq", 32'(irq_o), 32'd1);
    do_reset();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [NSRC-1:0] f;
      bit c, a;
      f = ($urandom_range(0, 2) == 0) ? NSRC'($urandom) : '0;
      c = ($urandom_range(0, 24) == 0);
      a = ($urandom_range(0, 3) == 0);
      step(f, c, a, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
